aes_byte_io: RTL and testbench

- Byte-serial I/O sequencer between the 8-bit pin interface and the 128-bit AES-128 encrypt core inside tt_um_aes_encrypt.
- Upstream: collects 16 key bytes and 16 plaintext bytes into 128-bit registers and pulses the core start.
- Downstream: captures the 128-bit ciphertext and streams it back out as 16 bytes with a valid/ready handshake.
- Byte order is FIPS-197: first byte on the bus is bits [127:120].

---
 rtl/aes_io_pkg.sv | 15 +
 rtl/aes_byte_shreg.sv | 44 ++++
 rtl/aes_byte_io.sv | 143 ++++++++++++++
 tb/tb_aes_byte_io.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_io_pkg.sv
// Shared types and sizes for the byte-serial AES-128 I/O sequencer.
// The state encoding is shared so that the top level and any debug logic agree on it.
package aes_io_pkg;

  localparam int AES_BYTES = 16;
  localparam int BLOCK_W   = 128;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    UNLOAD
  } state_t;

endpackage

// File: rtl/aes_byte_shreg.sv
// Byte-wide shift register holding one AES block or key.
// Bytes enter at the LSB end, so the first byte ends up in the top byte lane.
module aes_byte_shreg
  import aes_io_pkg::*;
#(
  parameter int NBYTES = AES_BYTES,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  load,
  input  logic [8*NBYTES-1:0]   load_data,
  input  logic                  shift,
  input  logic [7:0]            shift_in,
  output logic [8*NBYTES-1:0]   data,
  output logic [CNT_W-1:0]      cnt,
  output logic                  wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  // High on the shift that completes a full set of NBYTES bytes.
  assign wrap = shift & (cnt == LAST);

  // NOTE: the data register is reset even though it is wide, because its
  // contents are visible on the core key/block ports and must read 0 after reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
    end else if (ena) begin
      if (load) begin
        data <= load_data;
        cnt  <= '0;
      end else if (shift) begin
        data <= {data[8*NBYTES-9:0], shift_in};
        cnt  <= wrap ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_byte_io.sv
// Byte-serial sequencer between the 8-bit pin bus and a 128-bit AES-128 encrypt core:
// gathers key/plaintext bytes, starts the core, then streams the ciphertext out.
module aes_byte_io
  import aes_io_pkg::*;
#(
  parameter int NBYTES = AES_BYTES,
  parameter int CNT_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         in_byte,
  input  logic               in_valid,
  input  logic               in_is_key,
  output logic               in_ready,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               key_valid,
  output logic               err,
  output logic [BLOCK_W-1:0] core_key,
  output logic [BLOCK_W-1:0] core_block,
  output logic               core_start,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result
);

  state_t state, state_nxt;

  logic               in_accept;
  logic               key_shift, pt_shift, pt_drop;
  logic               out_shift, out_load;
  logic               key_wrap, pt_wrap, out_wrap;
  logic [CNT_W-1:0]   key_cnt, pt_cnt, out_cnt;
  logic [BLOCK_W-1:0] out_data;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == UNLOAD);

  assign in_accept = in_valid & in_ready & ena;
  assign key_shift = in_accept & in_is_key;
  assign pt_shift  = in_accept & ~in_is_key & key_valid;
  assign pt_drop   = in_accept & ~in_is_key & ~key_valid;
  assign out_shift = out_valid & out_ready & ena;

  aes_byte_shreg #(.NBYTES(NBYTES), .CNT_W(CNT_W)) u_key (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load      (1'b0),
    .load_data ('0),
    .shift     (key_shift),
    .shift_in  (in_byte),
    .data      (core_key),
    .cnt       (key_cnt),
    .wrap      (key_wrap)
  );

  aes_byte_shreg #(.NBYTES(NBYTES), .CNT_W(CNT_W)) u_pt (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load      (1'b0),
    .load_data ('0),
    .shift     (pt_shift),
    .shift_in  (in_byte),
    .data      (core_block),
    .cnt       (pt_cnt),
    .wrap      (pt_wrap)
  );

  // The output register is parallel-loaded from the core and drained from the top byte.
  aes_byte_shreg #(.NBYTES(NBYTES), .CNT_W(CNT_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load      (out_load),
    .load_data (core_result),
    .shift     (out_shift),
    .shift_in  (8'h00),
    .data      (out_data),
    .cnt       (out_cnt),
    .wrap      (out_wrap)
  );

  assign out_byte = out_data[BLOCK_W-1 -: 8];

  // Counters and low lanes that only matter inside the shift registers.
  logic unused;
  assign unused = ^{pt_cnt, out_cnt, out_data[BLOCK_W-9:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else if (ena) begin
      state <= state_nxt;
      // A new key invalidates the old one as soon as its first byte lands.
      if (key_shift) begin
        if (key_wrap) begin
          key_valid <= 1'b1;
        end else if (key_cnt == '0) begin
          key_valid <= 1'b0;
        end
      end
      if (pt_drop) begin
        err <= 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    out_load   = 1'b0;
    case (state)
      LOAD: begin
        if (pt_wrap) begin
          state_nxt = START;
        end
      end
      START: begin
        core_start = ena;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          out_load  = 1'b1;
          state_nxt = UNLOAD;
        end
      end
      UNLOAD: begin
        if (out_wrap) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

endmodule

// File: tb/tb_aes_byte_io.sv
// Directed/randomized bench for aes_byte_io with a behavioural stand-in for the AES core
// that returns the FIPS-197 C.1 ciphertext for the C.1 key/plaintext.
module tb_aes_byte_io;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic [7:0]   in_byte = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_is_key = 1'b0;
  logic         in_ready;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         key_valid;
  logic         err;
  logic [127:0] core_key;
  logic [127:0] core_block;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_byte_io dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .in_is_key   (in_is_key),
    .in_ready    (in_ready),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .key_valid   (key_valid),
    .err         (err),
    .core_key    (core_key),
    .core_block  (core_block),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: exact for the C.1 vector, otherwise an arbitrary but fixed mixing.
  function automatic logic [127:0] model_core(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a;
  endfunction

  // Byte i of a block in bus order (byte 0 is bits [127:120]).
  function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic is_key);
    in_byte   = b;
    in_is_key = is_key;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic send_range(input logic [127:0] v, input logic is_key, input int first,
                            input int last);
    for (int i = first; i <= last; i++) send(byte_of(v, i), is_key);
  endtask

  // Drain up to 'take' bytes, holding out_ready low for the first 'stall' valid cycles.
  // With 'junk' set, random input bytes are offered throughout and must be ignored.
  task automatic recv(input logic [127:0] exp, input int stall, input int take,
                      input logic junk);
    int waited = 0;
    int got = 0;
    int vcyc = 0;
    int stalled = 0;
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && waited < 100) begin
      if (junk) begin
        in_valid  = 1'b1;
        in_is_key = 1'($urandom_range(0, 1));
        in_byte   = 8'($urandom);
      end
      tick();
      waited++;
    end
    check("out_valid_arrives", {127'b0, out_valid}, 128'd1);
    while (got < take) begin
      if (out_valid !== 1'b1) break;
      vcyc++;
      if (stalled < stall) begin
        out_ready = 1'b0;
        check("stall_byte_stable", {120'b0, out_byte}, {120'b0, byte_of(exp, 0)});
        stalled++;
      end else begin
        out_ready = 1'b1;
        check($sformatf("out_byte%0d", got), {120'b0, out_byte}, {120'b0, byte_of(exp, got)});
        got++;
      end
      if (junk) begin
        in_valid  = 1'b1;
        in_is_key = 1'($urandom_range(0, 1));
        in_byte   = 8'($urandom);
      end
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (take == 16) begin
      check("bytes_accepted", 128'(got), 128'd16);
      check("valid_after_last", {127'b0, out_valid}, 128'd0);
      check("valid_cycles", 128'(vcyc), 128'(16 + stall));
      check("in_ready_after_unload", {127'b0, in_ready}, 128'd1);
    end
  endtask

  // Core stand-in: answers each start pulse after a random latency.
  initial begin
    logic [127:0] resp;
    int           lat;
    forever begin
      tick();
      if (core_start === 1'b1) begin
        resp = model_core(core_key, core_block);
        lat  = $urandom_range(1, 6);
        repeat (lat) tick();
        core_done   = 1'b1;
        core_result = resp;
        tick();
        core_done   = 1'b0;
        core_result = rand128();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] cur_key;
    logic [127:0] p;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", {127'b0, in_ready}, 128'd1);
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_key_valid", {127'b0, key_valid}, 128'd0);
    check("rst_err", {127'b0, err}, 128'd0);
    check("rst_core_start", {127'b0, core_start}, 128'd0);
    check("rst_out_byte", {120'b0, out_byte}, 128'd0);
    check("rst_core_key", core_key, 128'd0);
    check("rst_core_block", core_block, 128'd0);

    // core_done while loading must be ignored
    core_done   = 1'b1;
    core_result = '1;
    tick();
    core_done   = 1'b0;
    check("stray_done_out_valid", {127'b0, out_valid}, 128'd0);
    check("stray_done_in_ready", {127'b0, in_ready}, 128'd1);

    // Plaintext before any key: dropped, sticky error
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    check("early_pt_err", {127'b0, err}, 128'd1);
    check("early_pt_cnt", {124'b0, dut.u_pt.cnt}, 128'd0);
    check("early_pt_block", core_block, 128'd0);

    // Key load with ena dropped for 4 cycles after byte 7
    send_range(FIPS_KEY, 1'b1, 0, 6);
    ena       = 1'b0;
    in_valid  = 1'b1;
    in_is_key = 1'b1;
    in_byte   = 8'h07;
    repeat (4) tick();
    in_valid  = 1'b0;
    ena       = 1'b1;
    check("ena_hold_key_cnt", {124'b0, dut.u_key.cnt}, 128'd7);
    check("ena_hold_core_key", core_key, FIPS_KEY >> 72);
    check("ena_hold_key_valid", {127'b0, key_valid}, 128'd0);
    send_range(FIPS_KEY, 1'b1, 7, 15);
    check("key_valid_set", {127'b0, key_valid}, 128'd1);
    check("fips_core_key", core_key, FIPS_KEY);
    cur_key = FIPS_KEY;

    // C.1 block with back-pressure on the first output byte
    send_range(FIPS_PT, 1'b0, 0, 15);
    check("fips_start", {127'b0, core_start}, 128'd1);
    check("fips_core_block", core_block, FIPS_PT);
    in_valid  = 1'b1;
    in_is_key = 1'b0;
    in_byte   = 8'hee;
    tick();
    in_valid  = 1'b0;
    check("start_one_cycle", {127'b0, core_start}, 128'd0);
    recv(FIPS_CT, 5, 16, 1'b1);
    check("err_sticky", {127'b0, err}, 128'd1);
    check("key_kept_after_junk", core_key, FIPS_KEY);
    check("block_kept_after_junk", core_block, FIPS_PT);

    // Key reuse: plaintext only
    send_range(FIPS_PT, 1'b0, 0, 15);
    check("reuse_start", {127'b0, core_start}, 128'd1);
    recv(FIPS_CT, 0, 16, 1'b1);

    // Random blocks; first one interleaves a new key inside a half-loaded block
    for (int it = 0; it < 4; it++) begin
      p = rand128();
      if (it == 0) begin
        cur_key = rand128();
        send_range(p, 1'b0, 0, 7);
        send_range(cur_key, 1'b1, 0, 15);
        send_range(p, 1'b0, 8, 15);
      end else begin
        if (it % 2 == 1) begin
          cur_key = rand128();
          send_range(cur_key, 1'b1, 0, 15);
        end
        send_range(p, 1'b0, 0, 15);
      end
      check($sformatf("rnd%0d_start", it), {127'b0, core_start}, 128'd1);
      check($sformatf("rnd%0d_key", it), core_key, cur_key);
      check($sformatf("rnd%0d_block", it), core_block, p);
      recv(model_core(cur_key, p), $urandom_range(0, 3), 16, 1'b0);
    end

    // Reset in the middle of unloading
    send_range(FIPS_PT, 1'b0, 0, 15);
    recv(model_core(cur_key, FIPS_PT), 0, 5, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_out_valid", {127'b0, out_valid}, 128'd0);
    check("abort_key_valid", {127'b0, key_valid}, 128'd0);
    check("abort_in_ready", {127'b0, in_ready}, 128'd1);
    check("abort_err", {127'b0, err}, 128'd0);
    check("abort_key_cnt", {124'b0, dut.u_key.cnt}, 128'd0);
    check("abort_pt_cnt", {124'b0, dut.u_pt.cnt}, 128'd0);
    check("abort_out_cnt", {124'b0, dut.u_out.cnt}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
